pipe_ctrl_ms: RTL and testbench
===============================

PIPE_CTRL_MS -- requirements
Module: pipe_ctrl_ms

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, instruction address width.
REQ-002 SHALL have parameter NUM_STAGES, default 4, number of pipeline stages; stage 0 is fetch.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of hold requesters.
REQ-004 SHALL have parameter JUMP_STAGE, default 2, which is the stage resolving jumps.
REQ-005 SHALL have parameter FLUSH_CYC, default 1, range 1..15, which is the flush length in cycles after a jump.
REQ-006 SHALL have parameter HOLD_TMO, default 255, which is the consecutive-hold watchdog limit; 0 disables the watchdog.
REQ-007 SHALL use local SW = $clog2(NUM_STAGES) as the stage-index width.
REQ-008 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- jump_flag_i  in  1  jump request from the JUMP_STAGE stage
- jump_addr_i  in  ADDR_W  jump target
- hold_req_i  in  NUM_REQ  per-requester hold request
- hold_stage_i  in  NUM_REQ*SW  per-requester stage to hold at; requester r uses bits [r*SW +: SW]
- halt_req_i  in  1  debug halt request (level)
- stall_o  out  NUM_STAGES  stage i keeps its contents
- flush_o  out  NUM_STAGES  stage i loads a bubble
- jump_flag_o  out  1  redirect to pc
- jump_addr_o  out  ADDR_W  redirect target
- halted_o  out  1  core is halted
- hold_tmo_o  out  1  one-cycle watchdog pulse

Function
REQ-009 SHALL implement a registered FSM with states RUN, FLUSH and HALT.
REQ-010 SHALL treat the hold level k as the maximum hold_stage_i[r] over all r with hold_req_i[r]=1; hold is active when any requester is asserted.
REQ-011 In RUN with hold active and no jump, SHALL assert stall_o[i] for i<=k, assert flush_o[k+1] if k+1<NUM_STAGES, and keep all other bits at 0, combinationally in the same cycle.
REQ-012 SHALL ignore a hold_stage_i value >= NUM_STAGES for that requester.
REQ-013 In RUN with jump_flag_i=1, SHALL assert jump_flag_o=1 and jump_addr_o=jump_addr_i in the same cycle.
REQ-014 In that jump cycle, SHALL assert flush_o[i] for i<=JUMP_STAGE and drive stall_o=0; jump takes priority over hold.
REQ-015 On a jump with FLUSH_CYC>1, SHALL enter FLUSH next cycle with cnt=FLUSH_CYC-1.
REQ-016 In FLUSH, SHALL assert flush_o[i] for i<JUMP_STAGE, drive stall_o=0 and jump_flag_o=0, and decrement cnt each cycle.
REQ-017 SHALL leave FLUSH for RUN when cnt reaches 1 (the cycle after cnt==1 is RUN).
REQ-018 On a jump while in FLUSH, SHALL produce the REQ-013/014 outputs and reload cnt=FLUSH_CYC-1.
REQ-019 When halt_req_i=1 in RUN, SHALL flush stages 0..NUM_STAGES-1 in that cycle and enter HALT next cycle.
REQ-020 When halt_req_i=1 in FLUSH, SHALL complete the flush first and then go to HALT instead of RUN.
REQ-021 When a jump and a halt occur in the same RUN cycle, SHALL honour the jump outputs first and then take the REQ-019 path next cycle.
REQ-022 In HALT, SHALL assert stall_o all-ones, flush_o=0, halted_o=1, and ignore jump_flag_i and hold_req_i.
REQ-023 When halt_req_i=0 in HALT, SHALL return to RUN next cycle with halted_o=0 from that cycle.
REQ-024 SHALL count consecutive RUN cycles with hold active in a saturating hold counter of width $clog2(HOLD_TMO+1).
REQ-025 SHALL clear the hold counter on any cycle without active hold, or when not in RUN.
REQ-026 When the hold counter transitions to HOLD_TMO, SHALL pulse hold_tmo_o for exactly 1 cycle; no further pulse until the counter clears.
REQ-027 The watchdog is informational only; SHALL NOT alter stall_o or flush_o.

Reset
REQ-028 While rst_i=1, SHALL drive stall_o=0, flush_o all-ones, jump_flag_o=0, jump_addr_o=0, halted_o=0 and hold_tmo_o=0.
REQ-029 On the first clock edge with rst_i=1, SHALL set state=RUN, cnt=0 and hold counter=0.
REQ-030 Reset mid-FLUSH or mid-HALT SHALL abort to RUN with no residual flush cycles.

Verification
REQ-031 SHALL cover: NUM_STAGES=4, requester 1 holds at stage 1 -> stall_o=0011, flush_o=0100.
REQ-032 SHALL cover: requesters 0 and 2 hold at stages 0 and 2 simultaneously -> stall_o=0111, flush_o=1000.
REQ-033 SHALL cover: FLUSH_CYC=3, jump to 0x0000_0100 -> jump_flag_o=1 and flush_o=0111 in cycle 0, flush_o=0011 in cycles 1-2, RUN in cycle 3.
REQ-034 SHALL cover: second jump in flush cycle 1 -> new address output and 2 further flush cycles.
REQ-035 SHALL cover: halt_req_i held 5 cycles then dropped -> full flush, halted_o=1 for the HALT cycles, stall_o=1111, then RUN.
REQ-036 SHALL cover: HOLD_TMO=4, hold held 10 cycles -> single hold_tmo_o pulse on the 4th hold cycle; rst_i mid-hold -> all outputs at reset values.

Source files
------------

// File: rtl/pipe_ctrl_ms.sv
// Pipeline control: per-stage stall/flush from hold requests, jump redirect with a multi-cycle
// flush, debug halt, and a consecutive-hold watchdog.
module pipe_ctrl_ms #(
    parameter int ADDR_W     = 32,
    parameter int NUM_STAGES = 4,
    parameter int NUM_REQ    = 4,
    parameter int JUMP_STAGE = 2,
    parameter int FLUSH_CYC  = 1,
    parameter int HOLD_TMO   = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      jump_flag_i,
    input  logic [ADDR_W-1:0]         jump_addr_i,
    input  logic [NUM_REQ-1:0]        hold_req_i,
    input  logic [NUM_REQ*$clog2(NUM_STAGES)-1:0] hold_stage_i,
    input  logic                      halt_req_i,
    output logic [NUM_STAGES-1:0]     stall_o,
    output logic [NUM_STAGES-1:0]     flush_o,
    output logic                      jump_flag_o,
    output logic [ADDR_W-1:0]         jump_addr_o,
    output logic                      halted_o,
    output logic                      hold_tmo_o
);

    localparam int SW = $clog2(NUM_STAGES);
    localparam int HW = (HOLD_TMO > 0) ? $clog2(HOLD_TMO + 1) : 1;

    typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

    state_e          r_state, w_state_d;
    logic [3:0]      r_cnt, w_cnt_d;
    logic            r_halt_pend, w_halt_pend_d;
    logic [HW-1:0]   r_hcnt, w_hcnt_d;

    logic            w_hold_act;
    logic [SW-1:0]   w_k;
    logic [SW-1:0]   w_stg;

    // Hold level is the deepest stage among valid asserted requesters.
    always_comb begin
        w_hold_act = 1'b0;
        w_k        = '0;
        w_stg      = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            w_stg = hold_stage_i[r*SW +: SW];
            if (hold_req_i[r] && (int'(w_stg) < NUM_STAGES)) begin
                w_hold_act = 1'b1;
                if (w_stg > w_k) w_k = w_stg;
            end
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_halt_pend_d = r_halt_pend;
        stall_o       = '0;
        flush_o       = '0;
        jump_flag_o   = 1'b0;
        jump_addr_o   = '0;
        halted_o      = 1'b0;
        unique case (r_state)
            StRun: begin
                if (jump_flag_i) begin
                    jump_flag_o = 1'b1;
                    jump_addr_o = jump_addr_i;
                    for (int i = 0; i < NUM_STAGES; i++) flush_o[i] = (i <= JUMP_STAGE);
                    if (halt_req_i) begin
                        // The halt's full flush next cycle supersedes the jump flush window.
                        w_halt_pend_d = 1'b1;
                    end else if (FLUSH_CYC > 1) begin
                        w_state_d = StFlush;
                        w_cnt_d   = 4'(FLUSH_CYC - 1);
                    end
                end else if (halt_req_i || r_halt_pend) begin
                    flush_o       = '1;
                    w_state_d     = StHalt;
                    w_halt_pend_d = 1'b0;
                end else if (w_hold_act) begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        stall_o[i] = (i <= int'(w_k));
                        flush_o[i] = (i == int'(w_k) + 1);
                    end
                end
            end
            StFlush: begin
                w_halt_pend_d = r_halt_pend | halt_req_i;
                if (jump_flag_i) begin
                    jump_flag_o = 1'b1;
                    jump_addr_o = jump_addr_i;
                    for (int i = 0; i < NUM_STAGES; i++) flush_o[i] = (i <= JUMP_STAGE);
                    w_cnt_d = 4'(FLUSH_CYC - 1);
                end else begin
                    for (int i = 0; i < NUM_STAGES; i++) flush_o[i] = (i < JUMP_STAGE);
                    w_cnt_d = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_cnt_d = '0;
                        if (r_halt_pend || halt_req_i) begin
                            w_state_d     = StHalt;
                            w_halt_pend_d = 1'b0;
                        end else begin
                            w_state_d = StRun;
                        end
                    end
                end
            end
            StHalt: begin
                stall_o       = '1;
                halted_o      = 1'b1;
                w_halt_pend_d = 1'b0;
                if (!halt_req_i) w_state_d = StRun;
            end
            default: w_state_d = StRun;
        endcase
        if (rst_i) begin
            stall_o     = '0;
            flush_o     = '1;
            jump_flag_o = 1'b0;
            jump_addr_o = '0;
            halted_o    = 1'b0;
        end
    end

    // Watchdog: saturating count of consecutive held RUN cycles; pulse on reaching the limit.
    always_comb begin
        w_hcnt_d   = '0;
        hold_tmo_o = 1'b0;
        if (r_state == StRun && w_hold_act) begin
            w_hcnt_d = (r_hcnt == HW'(HOLD_TMO)) ? r_hcnt : r_hcnt + 1'b1;
            if (HOLD_TMO != 0 && !rst_i && r_hcnt == HW'(HOLD_TMO - 1)) hold_tmo_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StRun;
            r_cnt       <= '0;
            r_halt_pend <= 1'b0;
            r_hcnt      <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_halt_pend <= w_halt_pend_d;
            r_hcnt      <= w_hcnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_ms.sv
// Directed bench for pipe_ctrl_ms: NUM_STAGES=4, JUMP_STAGE=2, FLUSH_CYC=3, HOLD_TMO=4.
module tb_pipe_ctrl_ms;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [3:0]  hold_req_i;
    logic [7:0]  hold_stage_i;
    logic        halt_req_i;
    logic [3:0]  stall_o;
    logic [3:0]  flush_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halted_o;
    logic        hold_tmo_o;

    int n_chk = 0;
    int n_err = 0;

    pipe_ctrl_ms #(
        .ADDR_W     (32),
        .NUM_STAGES (4),
        .NUM_REQ    (4),
        .JUMP_STAGE (2),
        .FLUSH_CYC  (3),
        .HOLD_TMO   (4)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_req_i   (hold_req_i),
        .hold_stage_i (hold_stage_i),
        .halt_req_i   (halt_req_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .jump_flag_o  (jump_flag_o),
        .jump_addr_o  (jump_addr_o),
        .halted_o     (halted_o),
        .hold_tmo_o   (hold_tmo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change mid-cycle; outputs are sampled 1ns later, well before the next posedge.
    task automatic drv(input logic rst, input logic jf, input logic [31:0] ja,
                       input logic [3:0] hreq, input logic [7:0] hstg, input logic halt);
        @(negedge clk_i);
        rst_i        = rst;
        jump_flag_i  = jf;
        jump_addr_i  = ja;
        hold_req_i   = hreq;
        hold_stage_i = hstg;
        halt_req_i   = halt;
        #1;
    endtask

    task automatic expo(input string tag, input logic [3:0] st, input logic [3:0] fl,
                        input logic jf, input logic [31:0] ja, input logic hl, input logic tmo);
        chk({tag, ".stall"}, 32'(stall_o), 32'(st));
        chk({tag, ".flush"}, 32'(flush_o), 32'(fl));
        chk({tag, ".jflag"}, 32'(jump_flag_o), 32'(jf));
        chk({tag, ".jaddr"}, jump_addr_o, ja);
        chk({tag, ".halted"}, 32'(halted_o), 32'(hl));
        chk({tag, ".tmo"}, 32'(hold_tmo_o), 32'(tmo));
    endtask

    initial begin
        rst_i = 1'b1; jump_flag_i = 1'b0; jump_addr_i = '0;
        hold_req_i = '0; hold_stage_i = '0; halt_req_i = 1'b0;

        // Reset overrides active jump/hold/halt inputs
        drv(1, 1, 32'hDEAD, 4'b0001, 8'h00, 1); expo("rst", 4'h0, 4'hF, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("idle", 4'h0, 4'h0, 0, 0, 0, 0);

        // Hold patterns (counter reaches 3 then clears, so no timeout)
        drv(0, 0, 0, 4'b0010, 8'h04, 0);        expo("hold1", 4'b0011, 4'b0100, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0101, 8'h20, 0);        expo("hold02", 4'b0111, 4'b1000, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b1000, 8'hC0, 0);        expo("hold3", 4'b1111, 4'b0000, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("idle2", 4'h0, 4'h0, 0, 0, 0, 0);

        // Jump with FLUSH_CYC=3; jump beats hold, hold ignored in FLUSH
        drv(0, 1, 32'h100, 4'b0010, 8'h04, 0);  expo("jmp0", 4'h0, 4'b0111, 1, 32'h100, 0, 0);
        drv(0, 0, 0, 4'b0010, 8'h04, 0);        expo("jmp1", 4'h0, 4'b0011, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("jmp2", 4'h0, 4'b0011, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("jmp3", 4'h0, 4'b0000, 0, 0, 0, 0);

        // Second jump during flush reloads the count
        drv(0, 1, 32'h200, 4'b0000, 8'h00, 0);  expo("rj0", 4'h0, 4'b0111, 1, 32'h200, 0, 0);
        drv(0, 1, 32'h300, 4'b0000, 8'h00, 0);  expo("rj1", 4'h0, 4'b0111, 1, 32'h300, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("rj2", 4'h0, 4'b0011, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("rj3", 4'h0, 4'b0011, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("rj4", 4'h0, 4'b0000, 0, 0, 0, 0);

        // Halt held 5 cycles; jump and hold ignored while halted
        drv(0, 0, 0, 4'b0000, 8'h00, 1);        expo("hlt0", 4'h0, 4'hF, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 1);        expo("hlt1", 4'hF, 4'h0, 0, 0, 1, 0);
        drv(0, 1, 32'h40, 4'b0001, 8'h00, 1);   expo("hlt2", 4'hF, 4'h0, 0, 0, 1, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 1);        expo("hlt3", 4'hF, 4'h0, 0, 0, 1, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 1);        expo("hlt4", 4'hF, 4'h0, 0, 0, 1, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("hlt5", 4'hF, 4'h0, 0, 0, 1, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("hlt6", 4'h0, 4'h0, 0, 0, 0, 0);

        // Halt during FLUSH completes the flush, then halts
        drv(0, 1, 32'h400, 4'b0000, 8'h00, 0);  expo("hf0", 4'h0, 4'b0111, 1, 32'h400, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 1);        expo("hf1", 4'h0, 4'b0011, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("hf2", 4'h0, 4'b0011, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("hf3", 4'hF, 4'h0, 0, 0, 1, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("hf4", 4'h0, 4'h0, 0, 0, 0, 0);

        // Jump and halt together: jump outputs, then full flush, then HALT
        drv(0, 1, 32'h500, 4'b0000, 8'h00, 1);  expo("jh0", 4'h0, 4'b0111, 1, 32'h500, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 1);        expo("jh1", 4'h0, 4'hF, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("jh2", 4'hF, 4'h0, 0, 0, 1, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("jh3", 4'h0, 4'h0, 0, 0, 0, 0);

        // Watchdog: single pulse on 4th consecutive hold cycle
        for (int i = 1; i <= 10; i++) begin
            drv(0, 0, 0, 4'b0001, 8'h00, 0);
            expo($sformatf("wdg%0d", i), 4'b0001, 4'b0010, 0, 0, 0, (i == 4));
        end
        drv(1, 0, 0, 4'b0001, 8'h00, 0);        expo("wdgrst", 4'h0, 4'hF, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drv(0, 0, 0, 4'b0001, 8'h00, 0);
            expo($sformatf("wdgb%0d", i), 4'b0001, 4'b0010, 0, 0, 0, (i == 4));
        end
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("idle3", 4'h0, 4'h0, 0, 0, 0, 0);

        // Reset aborts FLUSH and HALT
        drv(0, 1, 32'h600, 4'b0000, 8'h00, 0);  expo("rf0", 4'h0, 4'b0111, 1, 32'h600, 0, 0);
        drv(1, 0, 0, 4'b0000, 8'h00, 0);        expo("rf1", 4'h0, 4'hF, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("rf2", 4'h0, 4'h0, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 1);        expo("rh0", 4'h0, 4'hF, 0, 0, 0, 0);
        drv(1, 0, 0, 4'b0000, 8'h00, 1);        expo("rh1", 4'h0, 4'hF, 0, 0, 0, 0);
        drv(0, 0, 0, 4'b0000, 8'h00, 0);        expo("rh2", 4'h0, 4'h0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
